seg_bin_display: RTL and testbench



---
 rtl/seg_bin_display.sv | 164 ++++++++++++++++
 tb/tb_seg_bin_display.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seg_bin_display.sv
// Binary-to-decimal 7-segment display driver: valid/ready input, double-dabble conversion,
// leading-zero blanking and overflow dashes. Define SEG_SIGN_EN for two's-complement input with a sign dash.
module seg_bin_display #(
  parameter int unsigned W    = 16,
  parameter int unsigned NDIG = 5,
  parameter int unsigned LZB  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  output logic                busy,
  output logic                done,
  output logic [7*NDIG-1:0]   hex_out
);

  localparam int unsigned BW = 4 * NDIG;
  localparam int unsigned HW = 7 * NDIG;
  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h40;
    endcase
  endfunction

  // Display shown out of reset: a single zero in digit0.
  function automatic logic [HW-1:0] reset_hex();
    logic [HW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(NDIG); k++)
      v[7*k +: 7] = (k == 0 || LZB == 0) ? 7'h40 : GLYPH_BLANK;
    return v;
  endfunction

  localparam logic [63:0]   LIM_POS = pow10(int'(NDIG));
  localparam logic [HW-1:0] RST_HEX = reset_hex();

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_UPDATE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_bin;
  logic [BW-1:0]   r_bcd;
  logic            r_ovf;

  logic [W-1:0]    w_mag;
  logic            w_ovf;
  logic [BW-1:0]   w_bcd_adj;
  logic [HW-1:0]   w_hex;
  int              w_msd;

`ifdef SEG_SIGN_EN
  localparam logic [63:0] LIM_NEG = pow10(int'(NDIG) - 1);
  logic r_neg;
  logic w_neg;

  // Negative inputs lose one digit to the sign dash, hence the lower limit.
  always_comb begin
    w_neg = in_data[W-1];
    w_mag = w_neg ? W'(-in_data) : in_data;
    w_ovf = w_neg ? (64'(w_mag) >= LIM_NEG) : (64'(w_mag) >= LIM_POS);
  end
`else
  always_comb begin
    w_mag = in_data;
    w_ovf = 64'(w_mag) >= LIM_POS;
  end
`endif

  // Add-3 correction applied before each shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < int'(NDIG); k++)
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
  end

  // Glyph selection with blanking, sign and overflow applied in rising priority.
  always_comb begin
    w_msd = 0;
    w_hex = '0;
    for (int k = 0; k < int'(NDIG); k++)
      if (r_bcd[4*k +: 4] != 4'd0) w_msd = k;
    for (int k = 0; k < int'(NDIG); k++) begin
      w_hex[7*k +: 7] = glyph(r_bcd[4*k +: 4]);
      if (LZB != 0 && k > w_msd) w_hex[7*k +: 7] = GLYPH_BLANK;
`ifdef SEG_SIGN_EN
      if (r_neg && ((LZB != 0) ? (k == w_msd + 1) : (k == int'(NDIG) - 1)))
        w_hex[7*k +: 7] = GLYPH_DASH;
`endif
      if (r_ovf) w_hex[7*k +: 7] = GLYPH_DASH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
`ifdef SEG_SIGN_EN
      r_neg    <= 1'b0;
`endif
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      hex_out  <= RST_HEX;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_bin    <= w_mag;
            r_bcd    <= '0;
            r_ovf    <= w_ovf;
`ifdef SEG_SIGN_EN
            r_neg    <= w_neg;
`endif
            r_cnt    <= CW'(W);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          hex_out  <= w_hex;
          done     <= 1'b1;
          busy     <= 1'b0;
          in_ready <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_bin_display.sv
// Bench for seg_bin_display: three instances (NDIG=5/LZB=1, NDIG=4/LZB=1, NDIG=5/LZB=0)
// share one input stream; expected displays are queued per transfer and checked on done.
module tb_seg_bin_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;

  logic        rdy5, busy5, done5;
  logic [34:0] hex5;
  logic        rdy4, busy4, done4;
  logic [27:0] hex4;
  logic        rdyz, busyz, donez;
  logic [34:0] hexz;

  seg_bin_display #(.W(16), .NDIG(5), .LZB(1)) u_d5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy5), .in_data(in_data),
    .busy(busy5), .done(done5), .hex_out(hex5));

  seg_bin_display #(.W(16), .NDIG(4), .LZB(1)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
    .busy(busy4), .done(done4), .hex_out(hex4));

  seg_bin_display #(.W(16), .NDIG(5), .LZB(0)) u_dz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdyz), .in_data(in_data),
    .busy(busyz), .done(donez), .hex_out(hexz));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] val;
    logic [34:0] e5;
    logic [27:0] e4;
    logic [34:0] ez;
  } vec_t;

  typedef struct {
    vec_t v;
    int   xfer;
  } rec_t;

  rec_t sb[$];
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done5) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        rec_t r;
        r = sb.pop_front();
        chk("hex_d5",   64'(hex5), 64'(r.v.e5));
        chk("hex_d4",   64'(hex4), 64'(r.v.e4));
        chk("hex_lz0",  64'(hexz), 64'(r.v.ez));
        chk("latency",  64'(cyc - r.xfer), 64'd17);
        chk("done_all", 64'({done4, donez}), 64'(2'b11));
        chk("idle_after_done", 64'({rdy5, busy5}), 64'(2'b10));
      end
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    do begin
      @(negedge clk);
      #1;
      i++;
    end while (sb.size() != 0 && i < 100);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout got=pending%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic send(input vec_t v);
    wait_idle();
    in_valid = 1'b1;
    in_data  = v.val;
    sb.push_back('{v, cyc + 1});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_hex_d5"}, 64'(hex5), 64'({{4{7'h7F}}, 7'h40}));
    chk({nm, "_hex_d4"}, 64'(hex4), 64'({{3{7'h7F}}, 7'h40}));
    chk({nm, "_hex_lz0"}, 64'(hexz), 64'({5{7'h40}}));
    chk({nm, "_ctrl"}, 64'({rdy5, busy5, done5, rdy4, rdyz}), 64'(5'b10011));
  endtask

  initial begin
    vec_t v;

    tbl[0]  = '{16'd12345, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, {4{7'h3F}},
                {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
    tbl[1]  = '{16'd0, {{4{7'h7F}}, 7'h40}, {{3{7'h7F}}, 7'h40}, {5{7'h40}}};
    tbl[2]  = '{16'd9999, {7'h7F, {4{7'h10}}}, {4{7'h10}}, {7'h40, {4{7'h10}}}};
    tbl[3]  = '{16'd7, {{4{7'h7F}}, 7'h78}, {{3{7'h7F}}, 7'h78}, {{4{7'h40}}, 7'h78}};
    tbl[4]  = '{16'd10000, {7'h79, {4{7'h40}}}, {4{7'h3F}}, {7'h79, {4{7'h40}}}};
    tbl[5]  = '{16'd1005, {7'h7F, 7'h79, 7'h40, 7'h40, 7'h12}, {7'h79, 7'h40, 7'h40, 7'h12},
                {7'h40, 7'h79, 7'h40, 7'h40, 7'h12}};
    tbl[6]  = '{16'd28760, {7'h24, 7'h00, 7'h78, 7'h02, 7'h40}, {4{7'h3F}},
                {7'h24, 7'h00, 7'h78, 7'h02, 7'h40}};
    tbl[7]  = '{16'd4096, {7'h7F, 7'h19, 7'h40, 7'h10, 7'h02}, {7'h19, 7'h40, 7'h10, 7'h02},
                {7'h40, 7'h19, 7'h40, 7'h10, 7'h02}};
    tbl[8]  = '{16'd32767, {7'h30, 7'h24, 7'h78, 7'h02, 7'h78}, {4{7'h3F}},
                {7'h30, 7'h24, 7'h78, 7'h02, 7'h78}};
    tbl[9]  = '{16'd10, {{3{7'h7F}}, 7'h79, 7'h40}, {7'h7F, 7'h7F, 7'h79, 7'h40},
                {{3{7'h40}}, 7'h79, 7'h40}};
    tbl[10] = '{16'd1000, {7'h7F, 7'h79, {3{7'h40}}}, {7'h79, {3{7'h40}}},
                {7'h40, 7'h79, {3{7'h40}}}};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++) send(tbl[i]);

`ifdef SEG_SIGN_EN
    send('{16'hFFF9, {{3{7'h7F}}, 7'h3F, 7'h78}, {7'h7F, 7'h7F, 7'h3F, 7'h78},
           {7'h3F, {3{7'h40}}, 7'h78}});
    send('{16'h8000, {5{7'h3F}}, {4{7'h3F}}, {5{7'h3F}}});
    send('{16'hFFFF, {{3{7'h7F}}, 7'h3F, 7'h79}, {7'h7F, 7'h7F, 7'h3F, 7'h79},
           {7'h3F, {3{7'h40}}, 7'h79}});
    send('{16'hD8F1, {7'h3F, {4{7'h10}}}, {4{7'h3F}}, {7'h3F, {4{7'h10}}}});
    send('{16'hD8F0, {5{7'h3F}}, {4{7'h3F}}, {5{7'h3F}}});
`else
    send('{16'hFFFF, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}, {4{7'h3F}},
           {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}});
`endif

    // in_valid held through a conversion: the second value waits for IDLE
    wait_idle();
    in_valid = 1'b1;
    in_data  = 16'd7;
    sb.push_back('{tbl[3], cyc + 1});
    @(posedge clk);
    #1 in_data = 16'd999;
    @(negedge clk);
    chk("busy_while_conv", 64'({rdy5, busy5}), 64'(2'b01));
    wait_idle();
    v = '{16'd999, {7'h7F, 7'h7F, {3{7'h10}}}, {7'h7F, {3{7'h10}}}, {7'h40, 7'h40, {3{7'h10}}}};
    sb.push_back('{v, cyc + 1});
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();

    // Reset in the fifth conversion cycle aborts the conversion
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'd12345;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midconv_reset");

    send('{16'd42, {{3{7'h7F}}, 7'h19, 7'h24}, {7'h7F, 7'h7F, 7'h19, 7'h24},
           {{3{7'h40}}, 7'h19, 7'h24}});
    wait_idle();
    repeat (25) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
